// File: rtl/mem_stream_pkg.sv
// mem_stream_pkg
// Shared definitions for the port-b stream reader: memory geometry used by
// the data memory stage and the reader FSM state encoding.
package mem_stream_pkg;

    localparam int MEM_ADDR_W = 18;
    localparam int MEM_DATA_W = 24;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        FETCH = 2'd1,
        DRAIN = 2'd2,
        DONE  = 2'd3
    } state_t;

endpackage

// File: rtl/mem_stream_reader_if.sv
// mem_stream_reader_if
// Valid/ready word stream leaving the reader.
//   out_valid : source has a word on out_data
//   out_ready : sink accepts the word this cycle
//   out_data  : streamed memory word
//   out_last  : final word of the transfer
// master = producer (the reader), slave = consumer.
interface mem_stream_reader_if
    import mem_stream_pkg::*;
#(
    parameter int DATA_W = MEM_DATA_W
);

    logic              out_valid;
    logic              out_ready;
    logic [DATA_W-1:0] out_data;
    logic              out_last;

    modport master (
        output out_valid,
        output out_data,
        output out_last,
        input  out_ready
    );

    modport slave (
        input  out_valid,
        input  out_data,
        input  out_last,
        output out_ready
    );

endinterface

// File: rtl/stream_fifo.sv
// stream_fifo
// Synchronous FIFO with registered storage; the head entry drives rdata.
//   clk, rst : clock, asynchronous active-high reset
//   push     : write wdata (performed when not full, or when full and popping)
//   pop      : drop the head entry (ignored when empty)
//   wdata    : entry to write
//   rdata    : current head entry
//   count    : occupancy, one bit wider than the pointers so full != empty
//   empty    : count is zero
//   full     : count equals DEPTH
module stream_fifo #(
    parameter int DEPTH = 4,
    parameter int WIDTH = 24
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     push,
    input  logic                     pop,
    input  logic [WIDTH-1:0]         wdata,
    output logic [WIDTH-1:0]         rdata,
    output logic [$clog2(DEPTH):0]   count,
    output logic                     empty,
    output logic                     full
);

    localparam int PTR_W = $clog2(DEPTH);
    localparam int CNT_W = PTR_W + 1;

    logic [WIDTH-1:0] mem_r [DEPTH];
    logic [PTR_W-1:0] wptr_r;
    logic [PTR_W-1:0] rptr_r;
    logic [CNT_W-1:0] count_r;
    logic             push_ok_s;
    logic             pop_ok_s;

    assign empty = (count_r == {CNT_W{1'b0}});
    assign full  = (count_r == CNT_W'(DEPTH));
    assign count = count_r;
    assign rdata = mem_r[rptr_r];

    // When full, a simultaneous pop frees the slot being written this cycle.
    assign pop_ok_s  = pop && !empty;
    assign push_ok_s = push && (!full || pop_ok_s);

    // Storage array, pointers (wrap naturally modulo DEPTH) and occupancy.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < DEPTH; i++) begin
                mem_r[i] <= {WIDTH{1'b0}};
            end
            wptr_r  <= {PTR_W{1'b0}};
            rptr_r  <= {PTR_W{1'b0}};
            count_r <= {CNT_W{1'b0}};
        end else begin
            if (push_ok_s) begin
                mem_r[wptr_r] <= wdata;
                wptr_r        <= wptr_r + PTR_W'(1'b1);
            end
            if (pop_ok_s) begin
                rptr_r <= rptr_r + PTR_W'(1'b1);
            end
            case ({push_ok_s, pop_ok_s})
                2'b10:   count_r <= count_r + CNT_W'(1'b1);
                2'b01:   count_r <= count_r - CNT_W'(1'b1);
                default: count_r <= count_r;
            endcase
        end
    end

endmodule

// File: rtl/mem_stream_reader.sv
// mem_stream_reader
// Sequential read master for port b of the data memory. A start pulse reads
// `length` consecutive words from `base_addr` and streams them on strm.
// Reads are only issued while the FIFO has a free slot for every word already
// in flight, so backpressure can never drop or duplicate a word.
//   clk, rst   : clock, asynchronous active-high reset
//   start      : transfer request, honoured only in IDLE
//   base_addr  : first word address (latched on accepted start)
//   length     : word count (latched on accepted start, 0 = immediate done)
//   busy       : high in FETCH and DRAIN
//   done       : one-cycle completion pulse
//   mem_addr   : port-b address
//   mem_rdata  : port-b read data, valid RD_LAT cycles after mem_addr
//   strm       : valid/ready output stream (master side)
module mem_stream_reader
    import mem_stream_pkg::*;
#(
    parameter int ADDR_W     = MEM_ADDR_W,
    parameter int DATA_W     = MEM_DATA_W,
    parameter int RD_LAT     = 1,
    parameter int FIFO_DEPTH = 4
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                start,
    input  logic [ADDR_W-1:0]   base_addr,
    input  logic [ADDR_W-1:0]   length,
    output logic                busy,
    output logic                done,
    output logic [ADDR_W-1:0]   mem_addr,
    input  logic [DATA_W-1:0]   mem_rdata,
    mem_stream_reader_if.master strm
);

    localparam int FCW = $clog2(FIFO_DEPTH) + 1;
    localparam int CW  = $clog2(FIFO_DEPTH + RD_LAT + 1) + 1;

    state_t              state_r;
    state_t              state_next;
    logic [ADDR_W-1:0]   addr_r;
    logic [ADDR_W-1:0]   remain_r;
    logic [ADDR_W-1:0]   words_left_r;
    logic [ADDR_W-1:0]   mem_addr_r;
    logic                issue_r;
    logic [RD_LAT-1:0]   inflight_r;
    logic [RD_LAT-1:0]   inflight_next_s;
    logic                busy_r;
    logic                done_r;

    logic [FCW-1:0]      fifo_count_s;
    logic                fifo_empty_s;
    logic                fifo_full_s;
    logic [DATA_W-1:0]   fifo_head_s;
    logic                push_s;
    logic                pop_s;
    logic [CW-1:0]       inflight_cnt_s;
    logic [CW-1:0]       credit_sum_s;
    logic                credit_ok_s;
    logic                issue_next_s;
    logic                accept_s;
    logic                drain_done_s;

    stream_fifo #(
        .DEPTH (FIFO_DEPTH),
        .WIDTH (DATA_W)
    ) u_fifo (
        .clk   (clk),
        .rst   (rst),
        .push  (push_s),
        .pop   (pop_s),
        .wdata (mem_rdata),
        .rdata (fifo_head_s),
        .count (fifo_count_s),
        .empty (fifo_empty_s),
        .full  (fifo_full_s)
    );

    // Issue flag leaving the RD_LAT-deep delay line marks mem_rdata as valid.
    assign push_s = inflight_r[RD_LAT-1];
    assign pop_s  = strm.out_valid && strm.out_ready;

    assign strm.out_valid = !fifo_empty_s;
    assign strm.out_data  = fifo_head_s;
    // Only one word is left to hand over, and it is sitting at the head.
    assign strm.out_last  = !fifo_empty_s && (words_left_r == ADDR_W'(1'b1));

    assign busy     = busy_r;
    assign done     = done_r;
    assign mem_addr = mem_addr_r;

    // Delay line input: this cycle's issue enters stage 0, others shift up.
    always_comb begin
        inflight_next_s    = {RD_LAT{1'b0}};
        inflight_next_s[0] = issue_r;
        for (int i = 1; i < RD_LAT; i++) begin
            inflight_next_s[i] = inflight_r[i-1];
        end
    end

    // Credit check for an issue next cycle: occupancy after this cycle's pop
    // plus every read still travelling (including the one on mem_addr now).
    always_comb begin
        inflight_cnt_s = {CW{1'b0}};
        for (int i = 0; i < RD_LAT; i++) begin
            inflight_cnt_s = inflight_cnt_s + CW'(inflight_r[i]);
        end
        credit_sum_s = CW'(fifo_count_s) + inflight_cnt_s + CW'(issue_r) - CW'(pop_s);
        // The full term is redundant with the sum; kept as a defensive guard.
        credit_ok_s  = (credit_sum_s < CW'(FIFO_DEPTH)) && !(fifo_full_s && !pop_s);
    end

    // Final word leaves this cycle and nothing else is buffered or pending.
    assign drain_done_s = pop_s
                       && (words_left_r == ADDR_W'(1'b1))
                       && (fifo_count_s == FCW'(1'b1))
                       && !issue_r
                       && (inflight_r == {RD_LAT{1'b0}});

    // FSM next state plus issue/accept decisions for the coming cycle.
    always_comb begin
        state_next   = state_r;
        issue_next_s = 1'b0;
        accept_s     = 1'b0;
        case (state_r)
            IDLE: begin
                if (start) begin
                    if (length != {ADDR_W{1'b0}}) begin
                        // First read goes out straight away; the FIFO is empty.
                        accept_s     = 1'b1;
                        issue_next_s = 1'b1;
                        if (length == ADDR_W'(1'b1)) begin
                            state_next = DRAIN;
                        end else begin
                            state_next = FETCH;
                        end
                    end else begin
                        state_next = DONE;
                    end
                end else begin
                    state_next = IDLE;
                end
            end
            FETCH: begin
                if (credit_ok_s) begin
                    issue_next_s = 1'b1;
                    if (remain_r == ADDR_W'(1'b1)) begin
                        state_next = DRAIN;
                    end else begin
                        state_next = FETCH;
                    end
                end else begin
                    state_next = FETCH;
                end
            end
            DRAIN: begin
                if (drain_done_s) begin
                    state_next = DONE;
                end else begin
                    state_next = DRAIN;
                end
            end
            DONE: begin
                state_next = IDLE;
            end
            default: begin
                state_next = IDLE;
            end
        endcase
    end

    // FSM state register with registered busy/done decoded from the next state.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_r <= IDLE;
            busy_r  <= 1'b0;
            done_r  <= 1'b0;
        end else begin
            state_r <= state_next;
            busy_r  <= (state_next == FETCH) || (state_next == DRAIN);
            done_r  <= (state_next == DONE);
        end
    end

    // Address generation, remaining-read and remaining-word counters.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            mem_addr_r   <= {ADDR_W{1'b0}};
            addr_r       <= {ADDR_W{1'b0}};
            remain_r     <= {ADDR_W{1'b0}};
            words_left_r <= {ADDR_W{1'b0}};
            issue_r      <= 1'b0;
            inflight_r   <= {RD_LAT{1'b0}};
        end else begin
            issue_r    <= issue_next_s;
            inflight_r <= inflight_next_s;
            if (accept_s) begin
                mem_addr_r   <= base_addr;
                addr_r       <= base_addr + ADDR_W'(1'b1);
                remain_r     <= length - ADDR_W'(1'b1);
                words_left_r <= length;
            end else begin
                if (issue_next_s) begin
                    // Address wraps modulo 2^ADDR_W by plain overflow.
                    mem_addr_r <= addr_r;
                    addr_r     <= addr_r + ADDR_W'(1'b1);
                    remain_r   <= remain_r - ADDR_W'(1'b1);
                end
                if (pop_s) begin
                    words_left_r <= words_left_r - ADDR_W'(1'b1);
                end
            end
        end
    end

endmodule

// File: tb/tb_mem_stream_reader.sv
module tb_mem_stream_reader;

    localparam int AW = 18;
    localparam int DW = 24;

    logic          clk = 1'b0;
    logic          rst;
    logic          start;
    logic [AW-1:0] base_addr;
    logic [AW-1:0] length;
    logic          busy;
    logic          done;
    logic [AW-1:0] mem_addr;
    logic [DW-1:0] mem_rdata;

    int errors = 0;
    int checks = 0;

    mem_stream_reader_if #(.DATA_W(DW)) strm ();

    mem_stream_reader #(
        .ADDR_W(AW), .DATA_W(DW), .RD_LAT(1), .FIFO_DEPTH(4)
    ) dut (
        .clk(clk), .rst(rst), .start(start), .base_addr(base_addr),
        .length(length), .busy(busy), .done(done), .mem_addr(mem_addr),
        .mem_rdata(mem_rdata), .strm(strm)
    );

    always #5 clk = ~clk;

    // Memory contents: mem[0x100+i] = 0xA00000+i, extended to every address.
    function automatic logic [DW-1:0] mem_fn(input logic [AW-1:0] a);
        return 24'hA00000 + {6'd0, a} - 24'h000100;
    endfunction

    // Port-b model with one cycle of read latency.
    always @(posedge clk) mem_rdata <= mem_fn(mem_addr);

    logic [DW-1:0] cap_data[$];
    logic          cap_last[$];
    logic [AW-1:0] addr_log[$];
    int first_valid_cyc, last_hs_cyc, done_cyc, done_cnt, max_out, stab_err;
    bit busy_seen, busy_at_done;

    task automatic pulse_start(input logic [AW-1:0] b, input logic [AW-1:0] l);
        @(negedge clk);
        base_addr = b;
        length    = l;
        start     = 1'b1;
    endtask

    // Runs the stream after a start pulse (cycle 0) until done or budget expiry.
    task automatic capture(input int budget, input bit bp, input int inject_cyc);
        int cyc = 0;
        int n_hs = 0;
        int outst;
        bit prev_stall = 1'b0;
        logic [DW-1:0] prev_data = '0;
        logic prev_last = 1'b0;
        logic [AW-1:0] base_l = base_addr;
        cap_data.delete(); cap_last.delete(); addr_log.delete();
        first_valid_cyc = -1; last_hs_cyc = -1; done_cyc = -1; done_cnt = 0;
        max_out = 0; stab_err = 0; busy_seen = 1'b0; busy_at_done = 1'b0;
        while (cyc < budget && done_cnt == 0) begin
            @(negedge clk);
            cyc++;
            start = (cyc == inject_cyc);
            if (cyc == inject_cyc) begin
                base_addr = 18'h00055;
                length    = 18'd2;
            end
            if (bp) strm.out_ready = ((cyc - 1) % 3 == 0);
            else    strm.out_ready = 1'b1;
            addr_log.push_back(mem_addr);
            if (busy) busy_seen = 1'b1;
            if (done) begin
                done_cnt++;
                done_cyc = cyc;
                busy_at_done = busy;
            end
            if (strm.out_valid && first_valid_cyc < 0) first_valid_cyc = cyc;
            if (prev_stall && (!strm.out_valid || strm.out_data !== prev_data
                               || strm.out_last !== prev_last)) stab_err++;
            prev_stall = strm.out_valid && !strm.out_ready;
            prev_data  = strm.out_data;
            prev_last  = strm.out_last;
            if (busy) begin
                outst = int'(AW'(mem_addr - base_l)) + 1 - n_hs;
                if (outst > max_out) max_out = outst;
            end
            if (strm.out_valid && strm.out_ready) begin
                cap_data.push_back(strm.out_data);
                cap_last.push_back(strm.out_last);
                last_hs_cyc = cyc;
                n_hs++;
            end
        end
        start = 1'b0;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        repeat (2) @(negedge clk);
        checks++; if (busy !== 1'b0) begin errors++; $display("FAIL reset_busy: got %0b want 0", busy); end
        checks++; if (done !== 1'b0) begin errors++; $display("FAIL reset_done: got %0b want 0", done); end
        checks++; if (strm.out_valid !== 1'b0) begin errors++; $display("FAIL reset_valid: got %0b want 0", strm.out_valid); end
        checks++; if (strm.out_data !== 24'h0) begin errors++; $display("FAIL reset_data: got %h want 0", strm.out_data); end
        checks++; if (mem_addr !== 18'h0) begin errors++; $display("FAIL reset_addr: got %h want 0", mem_addr); end
        rst = 1'b0;
        @(negedge clk);
        checks++; if (busy !== 1'b0 || strm.out_last !== 1'b0) begin errors++; $display("FAIL reset_release: busy %0b last %0b want 0 0", busy, strm.out_last); end
    endtask

    task automatic test_basic();
        pulse_start(18'h00100, 18'd5);
        capture(40, 1'b0, -1);
        checks++; if (addr_log.size() < 1 || addr_log[0] !== 18'h00100) begin errors++; $display("FAIL basic_first_addr: wrong first mem_addr, want 00100"); end
        checks++; if (first_valid_cyc != 3) begin errors++; $display("FAIL basic_latency: got cycle %0d want 3", first_valid_cyc); end
        checks++; if (cap_data.size() != 5) begin errors++; $display("FAIL basic_count: got %0d want 5", cap_data.size()); end
        for (int i = 0; i < cap_data.size() && i < 5; i++) begin
            checks++; if (cap_data[i] !== 24'hA00000 + 24'(i)) begin errors++; $display("FAIL basic_word%0d: got %h want %h", i, cap_data[i], 24'hA00000 + 24'(i)); end
            checks++; if (cap_last[i] !== (i == 4)) begin errors++; $display("FAIL basic_last%0d: got %0b want %0b", i, cap_last[i], (i == 4)); end
        end
        checks++; if (last_hs_cyc != 7) begin errors++; $display("FAIL basic_last_hs: got cycle %0d want 7", last_hs_cyc); end
        checks++; if (done_cyc != 8) begin errors++; $display("FAIL basic_done: got cycle %0d want 8", done_cyc); end
        checks++; if (busy_at_done !== 1'b0) begin errors++; $display("FAIL basic_busy_at_done: got %0b want 0", busy_at_done); end
        @(negedge clk);
        checks++; if (done !== 1'b0) begin errors++; $display("FAIL basic_done_pulse: got %0b want 0", done); end
    endtask

    task automatic test_backpressure();
        pulse_start(18'h00120, 18'd8);
        capture(200, 1'b1, -1);
        checks++; if (cap_data.size() != 8) begin errors++; $display("FAIL bp_count: got %0d want 8", cap_data.size()); end
        for (int i = 0; i < cap_data.size() && i < 8; i++) begin
            checks++; if (cap_data[i] !== 24'hA00020 + 24'(i)) begin errors++; $display("FAIL bp_word%0d: got %h want %h", i, cap_data[i], 24'hA00020 + 24'(i)); end
            checks++; if (cap_last[i] !== (i == 7)) begin errors++; $display("FAIL bp_last%0d: got %0b want %0b", i, cap_last[i], (i == 7)); end
        end
        checks++; if (stab_err != 0) begin errors++; $display("FAIL bp_stable: got %0d unstable stalls want 0", stab_err); end
        checks++; if (max_out > 4) begin errors++; $display("FAIL bp_outstanding: got %0d want <=4", max_out); end
        checks++; if (done_cnt != 1) begin errors++; $display("FAIL bp_done: got %0d pulses want 1", done_cnt); end
    endtask

    task automatic test_wrap();
        logic [AW-1:0] exp_a [4] = '{18'h3FFFE, 18'h3FFFF, 18'h00000, 18'h00001};
        logic [DW-1:0] exp_d [4] = '{24'hA3FEFE, 24'hA3FEFF, 24'h9FFF00, 24'h9FFF01};
        pulse_start(18'h3FFFE, 18'd4);
        capture(40, 1'b0, -1);
        for (int i = 0; i < 4 && i < addr_log.size(); i++) begin
            checks++; if (addr_log[i] !== exp_a[i]) begin errors++; $display("FAIL wrap_addr%0d: got %h want %h", i, addr_log[i], exp_a[i]); end
        end
        checks++; if (cap_data.size() != 4) begin errors++; $display("FAIL wrap_count: got %0d want 4", cap_data.size()); end
        for (int i = 0; i < cap_data.size() && i < 4; i++) begin
            checks++; if (cap_data[i] !== exp_d[i]) begin errors++; $display("FAIL wrap_word%0d: got %h want %h", i, cap_data[i], exp_d[i]); end
        end
    endtask

    task automatic test_zero_length();
        logic [AW-1:0] prev_addr;
        int moved = 0;
        @(negedge clk);
        prev_addr = mem_addr;
        pulse_start(18'h2AAAA, 18'd0);
        capture(20, 1'b0, -1);
        foreach (addr_log[i]) if (addr_log[i] !== prev_addr) moved++;
        checks++; if (done_cyc != 1) begin errors++; $display("FAIL zero_done: got cycle %0d want 1", done_cyc); end
        checks++; if (busy_seen) begin errors++; $display("FAIL zero_busy: got busy 1 want never"); end
        checks++; if (moved != 0) begin errors++; $display("FAIL zero_addr: got %0d changed cycles want 0", moved); end
        checks++; if (cap_data.size() != 0) begin errors++; $display("FAIL zero_words: got %0d want 0", cap_data.size()); end
    endtask

    task automatic test_ignored_start();
        int extra_done = 0;
        pulse_start(18'h00100, 18'd6);
        capture(60, 1'b0, 3);
        checks++; if (cap_data.size() != 6) begin errors++; $display("FAIL ign_count: got %0d want 6", cap_data.size()); end
        for (int i = 0; i < cap_data.size() && i < 6; i++) begin
            checks++; if (cap_data[i] !== 24'hA00000 + 24'(i)) begin errors++; $display("FAIL ign_word%0d: got %h want %h", i, cap_data[i], 24'hA00000 + 24'(i)); end
        end
        repeat (6) begin
            @(negedge clk);
            if (done || busy) extra_done++;
        end
        checks++; if (done_cnt + extra_done != 1) begin errors++; $display("FAIL ign_done: got %0d done/busy events want 1", done_cnt + extra_done); end
    endtask

    task automatic test_reset_mid();
        int n = 0;
        int cyc = 0;
        int late_done = 0;
        pulse_start(18'h00100, 18'd10);
        while (n < 3 && cyc < 30) begin
            @(negedge clk);
            cyc++;
            start = 1'b0;
            strm.out_ready = 1'b1;
            if (strm.out_valid) n++;
        end
        checks++; if (n != 3) begin errors++; $display("FAIL rstmid_pre: got %0d words want 3", n); end
        @(negedge clk);
        rst = 1'b1;
        #1;
        checks++; if (busy !== 1'b0 || done !== 1'b0) begin errors++; $display("FAIL rstmid_ctrl: busy %0b done %0b want 0 0", busy, done); end
        checks++; if (strm.out_valid !== 1'b0 || strm.out_last !== 1'b0) begin errors++; $display("FAIL rstmid_valid: valid %0b last %0b want 0 0", strm.out_valid, strm.out_last); end
        checks++; if (strm.out_data !== 24'h0 || mem_addr !== 18'h0) begin errors++; $display("FAIL rstmid_data: data %h addr %h want 0 0", strm.out_data, mem_addr); end
        @(negedge clk);
        rst = 1'b0;
        repeat (4) begin
            @(negedge clk);
            if (done) late_done++;
        end
        checks++; if (late_done != 0) begin errors++; $display("FAIL rstmid_nodone: got %0d pulses want 0", late_done); end
        pulse_start(18'h00200, 18'd2);
        capture(30, 1'b0, -1);
        checks++; if (cap_data.size() != 2) begin errors++; $display("FAIL rstmid_count: got %0d want 2", cap_data.size()); end
        for (int i = 0; i < cap_data.size() && i < 2; i++) begin
            checks++; if (cap_data[i] !== 24'hA00100 + 24'(i)) begin errors++; $display("FAIL rstmid_word%0d: got %h want %h", i, cap_data[i], 24'hA00100 + 24'(i)); end
            checks++; if (cap_last[i] !== (i == 1)) begin errors++; $display("FAIL rstmid_last%0d: got %0b want %0b", i, cap_last[i], (i == 1)); end
        end
    endtask

    task automatic test_back_to_back();
        pulse_start(18'h00100, 18'd3);
        capture(40, 1'b0, -1);
        checks++; if (done_cyc != last_hs_cyc + 1) begin errors++; $display("FAIL b2b_done: got cycle %0d want %0d", done_cyc, last_hs_cyc + 1); end
        pulse_start(18'h00140, 18'd2);
        capture(40, 1'b0, -1);
        checks++; if (first_valid_cyc != 3) begin errors++; $display("FAIL b2b_latency: got cycle %0d want 3", first_valid_cyc); end
        checks++; if (cap_data.size() != 2) begin errors++; $display("FAIL b2b_count: got %0d want 2", cap_data.size()); end
        for (int i = 0; i < cap_data.size() && i < 2; i++) begin
            checks++; if (cap_data[i] !== 24'hA00040 + 24'(i)) begin errors++; $display("FAIL b2b_word%0d: got %h want %h", i, cap_data[i], 24'hA00040 + 24'(i)); end
        end
    endtask

    initial begin
        rst            = 1'b1;
        start          = 1'b0;
        base_addr      = '0;
        length         = '0;
        strm.out_ready = 1'b1;
        test_reset();
        test_basic();
        test_backpressure();
        test_wrap();
        test_zero_length();
        test_ignored_start();
        test_reset_mid();
        test_back_to_back();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
